// File: rtl/square_pkg.sv
// rtl/square_pkg.sv - shared types and helpers for the rotating-square sequencer
package square_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN_CW    = 3'd1,
        DWELL_CW  = 3'd2,
        RUN_CCW   = 3'd3,
        DWELL_CCW = 3'd4,
        MANUAL    = 3'd5
    } sq_state_t;

    localparam int POS_COUNT = 16;
    localparam int POS_W     = $clog2(POS_COUNT);

    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos, input logic cw);
        return cw ? pos + POS_W'(1) : pos - POS_W'(1);
    endfunction
endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running step-tick divider, held at zero while idle or cleared
module tick_prescaler #(
    parameter int DIV = 5_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic tick_o
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (run_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = run_i && (cnt_q == LAST);
endmodule

// File: rtl/square_seq_ctrl.sv
// rtl/square_seq_ctrl.sv - auto/manual sequencer driving step, direction and enable of the square display
module square_seq_ctrl
    import square_pkg::*;
#(
    parameter int TICK_DIV    = 5_000_000,
    parameter int LAPS        = 2,
    parameter int DWELL_TICKS = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             auto_mode_i,
    input  logic             man_en_i,
    input  logic             man_cw_i,
    output logic             sq_en_o,
    output logic             sq_cw_o,
    output logic             sq_step_o,
    output logic [POS_W-1:0] pos_o,
    output logic [7:0]       lap_cnt_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int DW_W = $clog2(DWELL_TICKS + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_TICKS - 1);
    localparam logic [7:0]      LAP_LAST   = 8'(LAPS - 1);

    sq_state_t        state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [7:0]       lap_q, lap_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             step_q, step_d, done_q, done_d, busy_q, busy_d;
    logic             en_q, en_d, cw_q, cw_d;
    logic             tick;

    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state_d != state_q),
        .run_i  (state_q != IDLE),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        lap_d   = lap_q;
        dwell_d = dwell_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        if (stop_i) begin
            if (state_q != IDLE) begin
                state_d = IDLE;
                lap_d   = '0;
                dwell_d = '0;
            end
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_d = auto_mode_i ? RUN_CW : MANUAL;
                    lap_d   = '0;
                    dwell_d = '0;
                end
                // Every landing on position 0 closes a lap in either direction,
                // so each leg spans whole revolutions and ends back at 0.
                RUN_CW, RUN_CCW: if (tick) begin
                    step_d = 1'b1;
                    pos_d  = step_pos(pos_q, state_q == RUN_CW);
                    if (pos_d == '0) begin
                        if (lap_q == LAP_LAST) begin
                            lap_d   = '0;
                            state_d = (state_q == RUN_CW) ? DWELL_CW : DWELL_CCW;
                        end else begin
                            lap_d = lap_q + 8'd1;
                        end
                    end
                end
                DWELL_CW, DWELL_CCW: if (tick) begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        state_d = (state_q == DWELL_CW) ? RUN_CCW : IDLE;
                        done_d  = (state_q == DWELL_CCW);
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
                MANUAL: if (tick && man_en_i) begin
                    step_d = 1'b1;
                    pos_d  = step_pos(pos_q, man_cw_i);
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
        case (state_d)
            RUN_CW:    begin en_d = 1'b1;     cw_d = 1'b1;     end
            DWELL_CW:  begin en_d = 1'b0;     cw_d = 1'b1;     end
            RUN_CCW:   begin en_d = 1'b1;     cw_d = 1'b0;     end
            DWELL_CCW: begin en_d = 1'b0;     cw_d = 1'b0;     end
            MANUAL:    begin en_d = man_en_i; cw_d = man_cw_i; end
            default:   begin en_d = 1'b0;     cw_d = cw_q;     end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pos_q   <= '0;
            lap_q   <= '0;
            dwell_q <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            cw_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            lap_q   <= lap_d;
            dwell_q <= dwell_d;
            step_q  <= step_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            cw_q    <= cw_d;
        end
    end

    assign sq_en_o   = en_q;
    assign sq_cw_o   = cw_q;
    assign sq_step_o = step_q;
    assign pos_o     = pos_q;
    assign lap_cnt_o = lap_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
endmodule

// File: tb/tb_square_seq_ctrl.sv
// tb/tb_square_seq_ctrl.sv - randomized self-checking bench for square_seq_ctrl
module tb_square_seq_ctrl;
    localparam int TD        = 4;
    localparam int LAPS      = 1;
    localparam int DW        = 2;
    localparam int NPOS      = 16;
    localparam int LEG_CYC   = NPOS * LAPS * TD;
    localparam int DWELL_CYC = DW * TD;
    localparam int CCW_T0    = LEG_CYC + DWELL_CYC;
    localparam int DONE_T    = CCW_T0 + LEG_CYC + DWELL_CYC;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, stop = 1'b0, auto_mode = 1'b0, man_en = 1'b0, man_cw = 1'b0;
    logic sq_en, sq_cw, sq_step, busy, done;
    logic [3:0] pos;
    logic [7:0] lap_cnt;
    logic [16:0] obs, exp_v;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    square_seq_ctrl #(.TICK_DIV(TD), .LAPS(LAPS), .DWELL_TICKS(DW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .auto_mode_i(auto_mode),
        .man_en_i(man_en), .man_cw_i(man_cw), .sq_en_o(sq_en), .sq_cw_o(sq_cw),
        .sq_step_o(sq_step), .pos_o(pos), .lap_cnt_o(lap_cnt), .busy_o(busy), .done_o(done)
    );

    assign obs = {sq_en, sq_cw, sq_step, busy, done, lap_cnt, pos};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; auto_mode = 1'b0; man_en = 1'b0; man_cw = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    // Expected outputs t cycles after an auto start from position 0, from the leg/dwell timeline.
    function automatic logic [16:0] auto_exp(input int t);
        int s;
        logic en, cw, st, bz, dn;
        logic [7:0] lap;
        logic [3:0] p;
        en = 0; cw = 0; st = 0; bz = (t < DONE_T); dn = (t == DONE_T); lap = 0; p = 0;
        if (t <= LEG_CYC) begin
            s = t / TD; cw = 1; en = (t < LEG_CYC); st = (t % TD == 0) && (t > 0);
            p = 4'(s % NPOS); lap = (t < LEG_CYC) ? 8'(s / NPOS) : 8'd0;
        end else if (t < CCW_T0) begin
            cw = 1;
        end else if (t <= CCW_T0 + LEG_CYC) begin
            s = (t - CCW_T0) / TD; en = (t < CCW_T0 + LEG_CYC);
            st = ((t - CCW_T0) % TD == 0) && (t > CCW_T0);
            p = 4'((NPOS - s % NPOS) % NPOS); lap = en ? 8'(s / NPOS) : 8'd0;
        end
        return {en, cw, st, bz, dn, lap, p};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); stop = 1'($urandom); auto_mode = 1'($urandom);
            man_en = 1'($urandom); man_cw = 1'($urandom);
            cyc();
        end
        checks++; if (pos !== 4'd0) begin errors++; $display("FAIL reset_pos got %0d exp 0", pos); end
        checks++; if (sq_cw !== 1'b1) begin errors++; $display("FAIL reset_cw got %b exp 1", sq_cw); end
        checks++; if (sq_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", sq_en); end
        checks++; if (sq_step !== 1'b0) begin errors++; $display("FAIL reset_step got %b exp 0", sq_step); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (lap_cnt !== 8'd0) begin errors++; $display("FAIL reset_lap got %0d exp 0", lap_cnt); end
        rst = 1'b0; start = 1'b0; stop = 1'b0; auto_mode = 1'b0; man_en = 1'b0; man_cw = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_auto(input bit extra_starts);
        start = 1'b1; auto_mode = 1'b1;
        cyc();
        start = 1'b0; auto_mode = 1'($urandom);
        for (int t = 1; t <= DONE_T + 6; t++) begin
            start = extra_starts && (t < LEG_CYC) && ($urandom_range(0, 3) == 0);
            man_en = 1'($urandom); man_cw = 1'($urandom);
            cyc();
            exp_v = auto_exp(t);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL auto%0d t=%0d got en,cw,step,busy,done,lap,pos=%b,%b,%b,%b,%b,%0d,%0d exp %b,%b,%b,%b,%b,%0d,%0d",
                         extra_starts, t, obs[16], obs[15], obs[14], obs[13], obs[12], obs[11:4], obs[3:0],
                         exp_v[16], exp_v[15], exp_v[14], exp_v[13], exp_v[12], exp_v[11:4], exp_v[3:0]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_manual();
        logic [3:0] p;
        logic st;
        p = 4'd0;
        start = 1'b1; auto_mode = 1'b0; man_en = 1'b1; man_cw = 1'b0;
        cyc();
        start = 1'b0;
        checks++; if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, p}) begin
            errors++; $display("FAIL manual_entry got %h exp %h", obs, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, p});
        end
        for (int t = 1; t <= 64; t++) begin
            if (t > 8 && t <= 16) man_en = 1'b0;
            if (t > 16) begin man_en = 1'($urandom); man_cw = 1'($urandom); end
            cyc();
            st = (t % TD == 0) && man_en;
            if (st) p = man_cw ? p + 4'd1 : p - 4'd1;
            exp_v = {man_en, man_cw, st, 1'b1, 1'b0, 8'd0, p};
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL manual t=%0d got %h exp %h (pos %0d vs %0d)", t, obs, exp_v, obs[3:0], p);
            end
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        for (int t = 0; t < 4; t++) begin
            exp_v = {1'b0, man_cw, 1'b0, 1'b0, 1'b0, 8'd0, p};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL manual_stop t=%0d got %h exp %h", t, obs, exp_v); end
            man_en = 1'($urandom);
            cyc();
        end
        man_en = 1'b0; man_cw = 1'b0;
    endtask

    task automatic test_stop();
        int ts;
        do_reset();
        start = 1'b1; auto_mode = 1'b1;
        cyc();
        start = 1'b0;
        ts = 5 * TD + 1 + int'($urandom_range(0, TD - 1));
        for (int t = 1; t < ts; t++) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd5};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL stop_run got %h exp %h", obs, exp_v); end
        for (int t = 0; t < DONE_T; t++) begin
            cyc();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || pos !== 4'd5 || sq_step !== 1'b0) begin
                errors++; $display("FAIL stop_hold t=%0d got done=%b busy=%b pos=%0d step=%b exp 0,0,5,0", t, done, busy, pos, sq_step);
            end
        end
        start = 1'b1; stop = 1'b1; auto_mode = 1'($urandom);
        cyc();
        start = 1'b0; stop = 1'b0;
        for (int t = 0; t < 2 * TD; t++) begin
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL start_stop t=%0d got %h exp %h", t, obs, exp_v); end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        int tr;
        do_reset();
        start = 1'b1; auto_mode = 1'b1;
        cyc();
        start = 1'b0;
        tr = CCW_T0 + 1 + int'($urandom_range(0, LEG_CYC - 2));
        for (int t = 1; t < tr; t++) cyc();
        checks++;
        if (sq_cw !== 1'b0 || busy !== 1'b1 || sq_en !== 1'b1) begin
            errors++; $display("FAIL mid_ccw t=%0d got cw=%b busy=%b en=%b exp 0,1,1", tr - 1, sq_cw, busy, sq_en);
        end
        rst = 1'b1; start = 1'b1; stop = 1'($urandom); man_en = 1'b1;
        cyc();
        rst = 1'b0; start = 1'b0; stop = 1'b0; man_en = 1'b0;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0};
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_mid got %h exp %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_auto(1'b0);
        test_auto(1'b1);
        test_manual();
        test_stop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
